regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and hazard tracker for the 32x32 register file, which has a single synchronous write port.
- Two producers share that port through valid/ready handshakes, each with a one-entry holding buffer: the ALU result path and the load (memory) return path.
- Drives the register file's regwrite/write_reg/write_data from registered outputs.
- Flags read-after-write hazards on the two read addresses so the decode stage can stall.

Parameters:
- STARVE_LIMIT, 4: consecutive lost-arbitration cycles after which a buffered ALU entry gets priority (range 1..15).
- DATA_W, 32: write data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU write request
- alu_ready  output  1  ALU request accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load write request
- mem_ready  output  1  load request accepted this cycle
- mem_rd  input  5  load destination register
- mem_data  input  DATA_W  load data
- regwrite  output  1  register file write enable (registered)
- write_reg  output  5  register file write address (registered)
- write_data  output  DATA_W  register file write data (registered)
- read_reg1  input  5  decode-stage source address 1
- read_reg2  input  5  decode-stage source address 2
- hazard1  output  1  pending write to read_reg1
- hazard2  output  1  pending write to read_reg2

Behaviour:
- Reset (asynchronous, immediate):
  - Both buffers are cleared to invalid.
  - regwrite=0, write_reg=0, write_data=0.
  - Starvation counter=0, age bit=0.
  - alu_ready=mem_ready=0 while rst is high.
- Handshake:
  - X_ready = !rst && (!bufX_valid || bufX granted this cycle). This is combinational from buffer state and grant only, never from X_valid.
  - A transfer happens on a rising edge with X_valid && X_ready; rd and data are captured into bufX.
  - Held inputs must stay stable until the transfer.
- x0 writes: a request with rd==0 is accepted (ready rules unchanged) and discarded. It never occupies a buffer, never reaches the write port, and never raises a hazard.
- Arbitration is combinational over the buffers only:
  - Only one buffer valid: that buffer is granted.
  - Both valid, same rd: the older entry is granted (age bit). If both were captured on the same edge, ALU is older.
  - Both valid, different rd: mem wins, unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
- Starvation counter:
  - Increments on each edge where bufALU is valid and not granted, saturating at STARVE_LIMIT.
  - Clears on an ALU grant or when bufALU is empty.
- Grant effects at the edge:
  - The granted buffer is invalidated, unless it is refilled on that same edge.
  - regwrite<=1, write_reg<=rd, write_data<=data.
  - With no grant, regwrite<=0 and write_reg/write_data hold.
- Latency: accept at edge k, earliest output registers at edge k+1, register file written at edge k+2. Maximum throughput is one write per cycle.
- Hazards (combinational):
  - hazardN=1 iff read_regN!=0 and read_regN matches any of: valid bufALU rd, valid bufMEM rd, or (regwrite && write_reg).
  - hazardN falls in the cycle after the register file write edge.
- Simultaneous events:
  - A buffer may be granted and refilled on the same edge (back-to-back streaming).
  - Both producers may be accepted on the same edge.
- Asserting rst mid-operation discards buffered and in-flight writes. No register file write occurs after rst rises.

Test Plan:
- Single ALU write: alu rd=5, data=0xA5A5A5A5 at edge 1 -> regwrite=1, write_reg=5, write_data=0xA5A5A5A5 in the cycle after edge 2; hazard1=1 for read_reg1=5 from edge 1 until edge 3.
- Conflict: ALU rd=3 and mem rd=4 on the same edge -> mem written first, ALU one cycle later; both readies behave per the rule above, with no lost or duplicated write.
- Same-rd ordering: ALU rd=7 data=1 and mem rd=7 data=2 on the same edge -> write order is 1 then 2; final register value is 2.
- Starvation: STARVE_LIMIT=4, mem streaming back-to-back with ALU buffered -> ALU granted on the 5th arbitration; counter returns to 0.
- x0 writes: alu rd=0 data=0xFFFFFFFF -> accepted, regwrite stays 0, hazard1 stays 0 for read_reg1=0.
- Reset mid-flight: rst asserted with both buffers full and regwrite=1 -> all outputs 0 immediately, readies 0, no write after release until a new request.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back arbiter and hazard tracker for a 32x32 register file that has a
// single synchronous write port. Two producers (ALU result path and load
// return path) each feed a one-entry holding buffer through a valid/ready
// handshake. An arbiter picks one buffer per cycle and drives the registered
// write port. Read-after-write hazards are flagged for two decode-stage
// source addresses.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   alu_valid/ready/rd/data   ALU write request handshake
//   mem_valid/ready/rd/data   load write request handshake
//   regwrite/write_reg/
//   write_data                registered register file write port
//   read_reg1/2               decode-stage source addresses
//   hazard1/2                 pending write to read_reg1/2

module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  // ALU producer
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  // Load producer
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  // Register file write port
  output logic              regwrite,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  // Hazard detection
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic              hazard1,
  output logic              hazard2
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  // Holding buffers
  logic              alu_buf_valid_q, alu_buf_valid_d;
  logic [4:0]        alu_buf_rd_q, alu_buf_rd_d;
  logic [DATA_W-1:0] alu_buf_data_q, alu_buf_data_d;
  logic              mem_buf_valid_q, mem_buf_valid_d;
  logic [4:0]        mem_buf_rd_q, mem_buf_rd_d;
  logic [DATA_W-1:0] mem_buf_data_q, mem_buf_data_d;

  // Set when the mem entry is older than the ALU entry; only meaningful while
  // both buffers hold the same destination.
  logic              age_q, age_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  // Registered write port
  logic              regwrite_q, regwrite_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic grant_alu, grant_mem;
  logic alu_fire, mem_fire;
  logic alu_load, mem_load;

  // ---------------------------------------------------------------------------
  // Arbitration: looks only at buffer contents, never at the request inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_buf_valid_q && mem_buf_valid_q) begin
      if (alu_buf_rd_q == mem_buf_rd_q) begin
        // Same destination: the older write must land first.
        if (age_q) grant_mem = 1'b1;
        else       grant_alu = 1'b1;
      end else if (starve_cnt_q == StarveMax) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (alu_buf_valid_q) begin
      grant_alu = 1'b1;
    end else if (mem_buf_valid_q) begin
      grant_mem = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake. A buffer can accept when empty or when it drains this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_ready = !rst && (!alu_buf_valid_q || grant_alu);
    mem_ready = !rst && (!mem_buf_valid_q || grant_mem);
    alu_fire  = alu_valid && alu_ready;
    mem_fire  = mem_valid && mem_ready;
    // x0 writes complete the handshake but are dropped here.
    alu_load  = alu_fire && (alu_rd != 5'd0);
    mem_load  = mem_fire && (mem_rd != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Buffer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_buf_valid_d = alu_load || (alu_buf_valid_q && !grant_alu);
    alu_buf_rd_d    = alu_load ? alu_rd   : alu_buf_rd_q;
    alu_buf_data_d  = alu_load ? alu_data : alu_buf_data_q;

    mem_buf_valid_d = mem_load || (mem_buf_valid_q && !grant_mem);
    mem_buf_rd_d    = mem_load ? mem_rd   : mem_buf_rd_q;
    mem_buf_data_d  = mem_load ? mem_data : mem_buf_data_q;
  end

  // Age tracking: the entry that stays put while the other is (re)filled is
  // the older one. Simultaneous captures treat ALU as older.
  always_comb begin
    age_d = 1'b0;
    if (alu_buf_valid_d && mem_buf_valid_d) begin
      if (alu_load && !mem_load)      age_d = 1'b1;
      else if (mem_load)              age_d = 1'b0;
      else                            age_d = age_q;
    end
  end

  // Starvation counter: counts edges where a buffered ALU entry loses.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (alu_buf_valid_q && !grant_alu) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port next state
  // ---------------------------------------------------------------------------
  always_comb begin
    regwrite_d   = grant_alu || grant_mem;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_alu) begin
      write_reg_d  = alu_buf_rd_q;
      write_data_d = alu_buf_data_q;
    end else if (grant_mem) begin
      write_reg_d  = mem_buf_rd_q;
      write_data_d = mem_buf_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_buf_valid_q <= 1'b0;
      alu_buf_rd_q    <= 5'd0;
      alu_buf_data_q  <= '0;
      mem_buf_valid_q <= 1'b0;
      mem_buf_rd_q    <= 5'd0;
      mem_buf_data_q  <= '0;
      age_q           <= 1'b0;
      starve_cnt_q    <= 4'd0;
      regwrite_q      <= 1'b0;
      write_reg_q     <= 5'd0;
      write_data_q    <= '0;
    end else begin
      alu_buf_valid_q <= alu_buf_valid_d;
      alu_buf_rd_q    <= alu_buf_rd_d;
      alu_buf_data_q  <= alu_buf_data_d;
      mem_buf_valid_q <= mem_buf_valid_d;
      mem_buf_rd_q    <= mem_buf_rd_d;
      mem_buf_data_q  <= mem_buf_data_d;
      age_q           <= age_d;
      starve_cnt_q    <= starve_cnt_d;
      regwrite_q      <= regwrite_d;
      write_reg_q     <= write_reg_d;
      write_data_q    <= write_data_d;
    end
  end

  assign regwrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

  // ---------------------------------------------------------------------------
  // Hazards: any write not yet committed to the register file. The write port
  // register covers the cycle between grant and the register file edge.
  // ---------------------------------------------------------------------------
  function automatic logic pending_write(input logic [4:0] addr);
    pending_write = (addr != 5'd0) &&
                    ((alu_buf_valid_q && (alu_buf_rd_q == addr)) ||
                     (mem_buf_valid_q && (mem_buf_rd_q == addr)) ||
                     (regwrite_q      && (write_reg_q  == addr)));
  endfunction

  always_comb begin
    hazard1 = pending_write(read_reg1);
    hazard2 = pending_write(read_reg2);
  end

  // ---------------------------------------------------------------------------
  // Internal invariants
  // ---------------------------------------------------------------------------
  a_single_grant: assert property (@(posedge clk) disable iff (rst)
    !(grant_alu && grant_mem));
  a_no_x0_alu: assert property (@(posedge clk) disable iff (rst)
    !(alu_buf_valid_q && (alu_buf_rd_q == 5'd0)));
  a_no_x0_mem: assert property (@(posedge clk) disable iff (rst)
    !(mem_buf_valid_q && (mem_buf_rd_q == 5'd0)));
  a_starve_bound: assert property (@(posedge clk) disable iff (rst)
    starve_cnt_q <= StarveMax);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (STARVE_LIMIT=4, DATA_W=32).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic        hazard1, hazard2;

  int checks;
  int failures;

  regfile_wb_arbiter #(
    .STARVE_LIMIT(4),
    .DATA_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .regwrite  (regwrite),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .hazard1   (hazard1),
    .hazard2   (hazard2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
  endtask

  // Expect a write of (rd, data) on the port right now.
  task automatic expect_write(input string name, input logic [4:0] rd, input logic [31:0] data);
    checks++;
    if (regwrite !== 1'b1 || write_reg !== rd || write_data !== data) begin
      failures++;
      $display("FAIL %s: got regwrite=%b reg=%0d data=%h, want regwrite=1 reg=%0d data=%h",
               name, regwrite, write_reg, write_data, rd, data);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; mem_valid = 1'b1; mem_rd = 5'd9;
    read_reg1 = 5'd9; read_reg2 = 5'd0;
    tick();
    tick();
    checks++;
    if (regwrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_port: got %b/%0d/%h want 0/0/0", regwrite, write_reg, write_data);
    end
    expect_bit("reset_alu_ready", alu_ready, 1'b0);
    expect_bit("reset_mem_ready", mem_ready, 1'b0);
    expect_bit("reset_hazard1", hazard1, 1'b0);
    idle_inputs();
    rst = 1'b0;
    #1;
    expect_bit("post_reset_alu_ready", alu_ready, 1'b1);
    expect_bit("post_reset_mem_ready", mem_ready, 1'b1);
    tick();
    expect_bit("post_reset_regwrite", regwrite, 1'b0);
  endtask

  task automatic test_single_alu();
    read_reg1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_A5A5;
    expect_bit("single_ready", alu_ready, 1'b1);
    expect_bit("single_hazard_pre", hazard1, 1'b0);
    tick();                                  // edge 1: accepted
    idle_inputs();
    expect_bit("single_hazard_e1", hazard1, 1'b1);
    expect_bit("single_regwrite_e1", regwrite, 1'b0);
    tick();                                  // edge 2: output registers
    expect_write("single_write", 5'd5, 32'hA5A5_A5A5);
    expect_bit("single_hazard_e2", hazard1, 1'b1);
    tick();                                  // edge 3: register file written
    expect_bit("single_regwrite_e3", regwrite, 1'b0);
    expect_bit("single_hazard_e3", hazard1, 1'b0);
  endtask

  task automatic test_conflict();
    read_reg1 = 5'd3; read_reg2 = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
    expect_bit("conflict_alu_ready0", alu_ready, 1'b1);
    expect_bit("conflict_mem_ready0", mem_ready, 1'b1);
    tick();
    idle_inputs();
    expect_bit("conflict_alu_ready1", alu_ready, 1'b0);
    expect_bit("conflict_mem_ready1", mem_ready, 1'b1);
    expect_bit("conflict_hazard1", hazard1, 1'b1);
    expect_bit("conflict_hazard2", hazard2, 1'b1);
    tick();
    expect_write("conflict_mem_first", 5'd4, 32'h0000_0044);
    expect_bit("conflict_alu_ready2", alu_ready, 1'b1);
    tick();
    expect_write("conflict_alu_second", 5'd3, 32'h0000_0033);
    expect_bit("conflict_hazard2_clear", hazard2, 1'b0);
    tick();
    expect_bit("conflict_no_dup", regwrite, 1'b0);
    expect_bit("conflict_hazard1_clear", hazard1, 1'b0);
  endtask

  task automatic test_same_rd();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'd2;
    tick();
    idle_inputs();
    expect_bit("same_rd_alu_ready", alu_ready, 1'b1);
    expect_bit("same_rd_mem_ready", mem_ready, 1'b0);
    tick();
    expect_write("same_rd_first", 5'd7, 32'd1);
    tick();
    expect_write("same_rd_second", 5'd7, 32'd2);
    tick();
    expect_bit("same_rd_done", regwrite, 1'b0);
  endtask

  task automatic test_starvation();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00AA;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h100 + 32'd11;
    tick();                                  // both captured
    alu_valid = 1'b0;
    mem_rd = 5'd12; mem_data = 32'h100 + 32'd12;
    // Arbitrations 1..4 go to the streaming mem path.
    for (int k = 0; k < 4; k++) begin
      expect_bit($sformatf("starve_mem_ready_%0d", k), mem_ready, 1'b1);
      expect_bit($sformatf("starve_alu_ready_%0d", k), alu_ready, 1'b0);
      tick();
      expect_write($sformatf("starve_mem_write_%0d", k), 5'(11 + k), 32'h100 + 32'(11 + k));
      mem_rd   = 5'(13 + k);
      mem_data = 32'h100 + 32'(13 + k);
    end
    // Fifth arbitration: ALU wins.
    expect_bit("starve_alu_ready_5", alu_ready, 1'b1);
    expect_bit("starve_mem_ready_5", mem_ready, 1'b0);
    tick();
    expect_write("starve_alu_write", 5'd10, 32'h0000_00AA);
    expect_bit("starve_mem_ready_after", mem_ready, 1'b1);
    tick();                                  // rd 16 accepted here
    mem_valid = 1'b0;
    expect_write("starve_mem_15", 5'd15, 32'h100 + 32'd15);
    tick();
    expect_write("starve_mem_16", 5'd16, 32'h100 + 32'd16);
    tick();
    expect_bit("starve_done", regwrite, 1'b0);
    idle_inputs();
  endtask

  task automatic test_x0();
    read_reg1 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    expect_bit("x0_ready", alu_ready, 1'b1);
    tick();
    idle_inputs();
    expect_bit("x0_ready_after", alu_ready, 1'b1);
    expect_bit("x0_hazard", hazard1, 1'b0);
    expect_bit("x0_regwrite1", regwrite, 1'b0);
    tick();
    expect_bit("x0_regwrite2", regwrite, 1'b0);
  endtask

  task automatic test_reset_midflight();
    read_reg1 = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0303;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0404;
    tick();
    alu_valid = 1'b0;
    mem_rd = 5'd6; mem_data = 32'h0000_0606;
    tick();                                  // both buffers full, port writing rd 4
    idle_inputs();
    expect_write("midflight_setup", 5'd4, 32'h0000_0404);
    rst = 1'b1;
    #1;
    checks++;
    if (regwrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      failures++;
      $display("FAIL midflight_reset_port: got %b/%0d/%h want 0/0/0",
               regwrite, write_reg, write_data);
    end
    expect_bit("midflight_alu_ready", alu_ready, 1'b0);
    expect_bit("midflight_mem_ready", mem_ready, 1'b0);
    expect_bit("midflight_hazard", hazard1, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_bit($sformatf("midflight_no_write_%0d", k), regwrite, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    read_reg2 = 5'd2;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    tick();
    alu_rd = 5'd2; alu_data = 32'h1111_0002;
    expect_bit("b2b_ready1", alu_ready, 1'b1);
    tick();
    expect_write("b2b_w1", 5'd1, 32'h1111_0001);
    expect_bit("b2b_hazard2", hazard2, 1'b1);
    alu_rd = 5'd3; alu_data = 32'h1111_0003;
    expect_bit("b2b_ready2", alu_ready, 1'b1);
    tick();
    idle_inputs();
    expect_write("b2b_w2", 5'd2, 32'h1111_0002);
    tick();
    expect_write("b2b_w3", 5'd3, 32'h1111_0003);
    expect_bit("b2b_hazard2_clear", hazard2, 1'b0);
    tick();
    expect_bit("b2b_done", regwrite, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    test_reset();
    test_single_alu();
    test_conflict();
    test_same_rd();
    test_starvation();
    test_x0();
    test_reset_midflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
